// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - single-lane TMDS receive decoder with bit-slip alignment
// Optional lock-loss counter: define TMDS_DEC_ERRCNT_EN to build err_count.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_CYCLES = 2048
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [9:0]  tmds_word,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        locked,
  output logic [3:0]  phase,
  output logic        err,
  output logic [15:0] err_count
);

  localparam int CW = (SEARCH_CYCLES > 2) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SEARCH_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_COUNT);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    prev_q;
  logic [9:0]    word_q, word_d;
  logic [3:0]    phase_q, phase_d, phase_inc;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
  logic [RW-1:0] run_q, run_d;
  logic [7:0]    data_q, dec_d;
  logic [1:0]    ctrl_q, tok_val;
  logic          de_q, err_q, err_d, tok_hit, cnt_exp;
  logic [19:0]   window;
  logic [4:0]    sel;
  logic [7:0]    qp;

  // prev holds the older word, so lower window bits were received first
  assign window    = {tmds_word, prev_q};
  assign sel       = {1'b0, phase_q};
  assign word_d    = window[sel +: 10];
  assign phase_inc = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
  assign cnt_exp   = (cnt_q >= CNT_MAX);
  assign cnt_sat   = cnt_exp ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (word_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  always_comb begin
    qp       = word_q[9] ? ~word_q[7:0] : word_q[7:0];
    dec_d    = 8'h00;
    dec_d[0] = qp[0];
    for (int i = 1; i < 8; i++) begin
      dec_d[i] = word_q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    phase_d = phase_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (tok_hit) begin
          state_d = VERIFY;
          run_d   = RW'(1);
          cnt_d   = cnt_sat;
        end else if (cnt_exp) begin
          phase_d = phase_inc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      VERIFY: begin
        cnt_d = cnt_sat;
        if (tok_hit) begin
          run_d = run_q + 1'b1;
          if (run_q + 1'b1 == RUN_MAX) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end else begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (tok_hit) begin
          cnt_d = '0;
        end else if (cnt_exp) begin
          state_d = SEARCH;
          err_d   = 1'b1;
          phase_d = phase_inc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      prev_q  <= '0;
      word_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= tmds_word;
      word_q  <= word_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
      // decode against the next state so the locking token itself is emitted
      if (state_d == LOCKED) begin
        de_q   <= ~tok_hit;
        data_q <= tok_hit ? 8'h00 : dec_d;
        ctrl_q <= tok_hit ? tok_val : ctrl_q;
      end else begin
        de_q   <= 1'b0;
        data_q <= 8'h00;
        ctrl_q <= 2'b00;
      end
    end
  end

`ifdef TMDS_DEC_ERRCNT_EN
  logic [15:0] errcnt_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= '0;
    end else if (err_d && (errcnt_q != 16'hFFFF)) begin
      errcnt_q <= errcnt_q + 16'd1;
    end
  end

  assign err_count = errcnt_q;
`else
  assign err_count = 16'h0000;
`endif

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = (state_q == LOCKED);
  assign phase  = phase_q;
  assign err    = err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

  localparam int SC = 64;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
`ifdef TMDS_DEC_ERRCNT_EN
  localparam int EXP_ERRCNT = 1;
`else
  localparam int EXP_ERRCNT = 0;
`endif
  localparam int K_LOCK = 0, K_DATA = 1, K_CTRL = 2, K_ERR = 3, K_PHASE = 4;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  tmds_word = '0;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        de, locked, err;
  logic [3:0]  phase;
  logic [15:0] err_count;

  tmds_channel_decoder #(.LOCK_COUNT(16), .SEARCH_CYCLES(SC)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .tmds_word(tmds_word),
    .data(data), .ctrl(ctrl), .de(de), .locked(locked),
    .phase(phase), .err(err), .err_count(err_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int kind;
    int a;
    int b;
  } exp_t;

  exp_t exp_q[$];
  bit   sq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void ex(input int k, input int a, input int b);
    exp_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endfunction

  task automatic pop(input int kind, output exp_t e, output bit ok);
    e.kind = -1; e.a = 0; e.b = 0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      ok = 1'b0;
      $display("FAIL unexpected_event kind=%0d actual=present required=none at cycle %0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      ok = 1'b1;
      chk("event_kind", e.kind, kind);
    end
  endtask

  logic       locked_p = 1'b0;
  logic [1:0] ctrl_p = '0;
  logic [3:0] phase_p = '0;
  int         last_pc = 0;

  always @(negedge pixel_clk) begin : monitor
    exp_t e;
    bit ok;
    if (rst_n) begin
      if (locked && !locked_p) begin
        pop(K_LOCK, e, ok);
        if (ok) begin
          chk("lock_phase", int'(phase), e.a);
          chk("lock_ctrl", int'(ctrl), e.b);
          chk("lock_de", int'(de), 0);
        end
      end
      if (de) begin
        pop(K_DATA, e, ok);
        if (ok) chk("data", int'(data), e.a);
      end
      if (locked && locked_p && ctrl != ctrl_p) begin
        pop(K_CTRL, e, ok);
        if (ok) begin
          chk("ctrl", int'(ctrl), e.a);
          chk("ctrl_de", int'(de), 0);
        end
      end
      if (err) begin
        pop(K_ERR, e, ok);
        if (ok) begin
          chk("err_phase", int'(phase), e.a);
          chk("err_locked", int'(locked), 0);
          chk("err_count", int'(err_count), e.b);
        end
      end
      if (phase != phase_p) begin
        pop(K_PHASE, e, ok);
        if (ok) begin
          chk("phase", int'(phase), e.a);
          if (e.b != 0) chk("phase_interval", cyc - last_pc, e.b);
        end
        last_pc <= cyc;
      end
    end
    locked_p <= locked;
    ctrl_p   <= ctrl;
    phase_p  <= phase;
  end

  task automatic q_word(input logic [9:0] w, input int n);
    repeat (n) for (int i = 0; i < 10; i++) sq.push_back(w[i]);
  endtask

  task automatic q_fill(input int n);
    repeat (n) sq.push_back(1'b0);
  endtask

  task automatic step(input int n);
    logic [9:0] w;
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
      w = '0;
      for (int i = 0; i < 10; i++) if (sq.size() > 0) w[i] = sq.pop_front();
      tmds_word = w;
    end
  endtask

  task automatic drain();
    while (sq.size() >= 10) step(1);
  endtask

  task automatic expect_drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge pixel_clk);
    #3;
    rst_n = 1'b0;
    sq.delete();
    tmds_word = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values
    step(3);
    chk("rst_data", int'(data), 0);
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_de", int'(de), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_phase", int'(phase), 0);
    rst_n = 1'b1;

    // phase-0 lock, then decode data and tokens
    ex(K_LOCK, 0, 0);
    ex(K_DATA, 8'h00, 0);
    ex(K_DATA, 8'hFE, 0);
    ex(K_CTRL, 3, 0);
    ex(K_CTRL, 0, 0);
    q_word(TOK00, 20);
    q_word(10'h100, 1);
    q_word(10'h2FF, 1);
    q_word(TOK11, 1);
    q_word(TOK00, 8);
    drain();
    expect_drained("t2_events");

    // 3-bit offset: phase search then lock at phase 3
    do_reset();
    ex(K_PHASE, 1, 0);
    ex(K_PHASE, 2, SC);
    ex(K_PHASE, 3, SC);
    ex(K_LOCK, 3, 3);
    q_fill(3);
    q_word(TOK11, 300);
    step(260);
    expect_drained("t3_lock_events");
    chk("t3_locked_before_rst", int'(locked), 1);

    // asynchronous reset while locked
    @(posedge pixel_clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_de", int'(de), 0);
    chk("midrst_ctrl", int'(ctrl), 0);
    chk("midrst_data", int'(data), 0);
    chk("midrst_phase", int'(phase), 0);
    sq.delete();
    tmds_word = '0;
    step(2);
    rst_n = 1'b1;
    ex(K_LOCK, 0, 0);
    q_word(TOK00, 20);
    drain();
    expect_drained("relock_events");

    // broken token run returns to SEARCH
    do_reset();
    q_word(TOK00, 10);
    q_word(10'h100, 1);
    q_word(TOK00, 15);
    q_word(10'h100, 5);
    drain();
    step(3);
    chk("t5_locked", int'(locked), 0);
    chk("t5_phase", int'(phase), 0);
    expect_drained("t5_no_events");

    // lock at phase 9, then lose lock after SC data words
    do_reset();
    ex(K_PHASE, 1, 0);
    for (int p = 2; p <= 9; p++) ex(K_PHASE, p, SC);
    ex(K_LOCK, 9, 0);
    for (int i = 0; i < SC - 1; i++) ex(K_DATA, 8'h00, 0);
    ex(K_ERR, 0, EXP_ERRCNT);
    ex(K_PHASE, 0, 0);
    q_fill(9);
    q_word(TOK00, 9 * SC + 30);
    q_word(10'h100, SC + 20);
    drain();
    step(3);
    expect_drained("t6_events");
    chk("t6_locked", int'(locked), 0);
    chk("t6_err_count", int'(err_count), EXP_ERRCNT);

    do_reset();
    chk("final_rst_err_count", int'(err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
